riscv_soc_top: RTL and testbench
================================

// Module: riscv_soc_top
// PURPOSE
//  SoC top around the RISC-V core (instantiated as cpu, provided separately).
//  Provides reset conditioning, a byte-wide RAM, memory-mapped I/O decode, an 8N1 UART and a status LED.
//  Sits directly under the board or simulation harness.
//  With SIM=1 the UART is bypassed, so console output and program halt run through simulator tasks.
// PARAMETERS
//  SIM            0          1 = simulation: console via $write, halt via $finish
//  SYS_CLK_FREQ   100000000  EXCLK frequency, Hz
//  UART_BAUD_RATE 115200     UART bit rate
//  RAM_ADDR_WIDTH 17         RAM depth 2**RAM_ADDR_WIDTH bytes (128 KiB)
// PORTS
//  EXCLK  in   1  system clock; the only clock, all logic on posedge
//  btnC   in   1  reset, asynchronous, active-low
//  Tx     out  1  UART transmit line, idle high
//  Rx     in   1  UART receive line, asynchronous to EXCLK
//  led    out  1  1 = core running (internal reset released)
// BEHAVIOUR
//  Reset:
//  - btnC low asynchronously clears every flop.
//  - Release is synchronised by a 2-flop chain; the core's active-high rst_in drops
//    2 EXCLK edges after btnC rises.
//  - Reset values: led=0, Tx=1, UART idle, rx_valid=0, tx_busy=0.
//  - RAM contents are not reset.
//  Core bus (one byte per cycle):
//  - Signals: mem_a[31:0], mem_dout[7:0], mem_wr, mem_din[7:0].
//  - rdy_in=1 whenever not in reset.
//  - io_buffer_full = tx_busy; forced to 0 when SIM=1.
//  Decode on mem_a[17:16]:
//  - 2'b11 selects I/O.
//  - Anything else selects RAM[mem_a[RAM_ADDR_WIDTH-1:0]].
//  - Bits 31:18 are ignored.
//  RAM:
//  - Write takes effect at the posedge where mem_wr=1.
//  - Read is synchronous, 1-cycle latency.
//  - A read of an address written in the same cycle returns the old data.
//  Read mux: selected by the decode registered from the previous cycle, so RAM and I/O
//  data have identical 1-cycle latency.
//  I/O map (offset mem_a[2:0], base 0x30000):
//  - 0x30000 W: transmit byte. SIM=1: $write("%c") immediately.
//    SIM=0: load the UART transmitter; ignored if tx_busy.
//  - 0x30000 R: return the rx holding byte and clear rx_valid (pop).
//    Returns 0x00 if empty; SIM=1 always 0x00.
//  - 0x30004 W: SIM=1: $display("IO:Return"), then $finish. SIM=0: no effect.
//  - 0x30004 R: {7'b0, rx_valid}.
//  - Other I/O offsets: reads 0x00, writes ignored.
//  UART, 8N1, LSB first:
//  - DIV = SYS_CLK_FREQ/UART_BAUD_RATE clocks per bit.
//  - TX states: IDLE, START, DATA(8), STOP.
//  - tx_busy is 1 from the load cycle until the end of the stop bit.
//  - RX: Rx passes a 2-flop synchroniser.
//  - RX start is detected on a falling edge; the start bit is re-checked at DIV/2.
//    If it is high again, return to idle (glitch).
//  - Data bits are sampled at bit centres. The stop bit must be 1, otherwise the frame is discarded.
//  - A good frame sets rx_valid and loads the holding byte.
//  - If rx_valid is already 1 the new byte is dropped (overrun); the old byte is kept.
//  - A pop and a frame completing in the same cycle: the pop returns the old byte,
//    then the new byte is stored and rx_valid stays 1.
//  led = ~internal_reset.
// TESTING
//  1. btnC=0 for 25 cycles, then 1 -> led=0, Tx=1 throughout reset; led=1 and rdy_in=1 two edges after release.
//  2. Write 0xA5 to 0x00010, read 0x00010 -> mem_din=0xA5 one cycle after the read address.
//  3. Write 0xFF to 0x1FFFF, read 0x1FFFF and 0x3FFFF -> RAM byte is 0xFF; the 0x3FFFF read returns 0x00 (I/O).
//  4. SIM=1, write 0x48 then 0x69 to 0x30000, then any byte to 0x30004 -> console prints "Hi", then "IO:Return", and simulation ends.
//  5. SIM=0, DIV=16, write 0x55 to 0x30000 -> Tx = 0 then 1,0,1,0,1,0,1,0 then 1, each bit 16 clocks; tx_busy=1 for 160 clocks; a second write while busy is ignored.
//  6. SIM=0, drive the Rx frame 0x3C, then 0x7E with no pop -> 0x30004 reads 0x01; 0x30000 reads 0x3C (0x7E dropped); 0x30004 then reads 0x00.

Source files
------------

// File: rtl/riscv_soc_top_if.sv
// Core-side byte bus of the SoC. The core (or a harness standing in for it)
// drives the master side. The SoC top is the slave. The sim_* strobes carry
// console and halt requests out to the simulation harness when SIM=1.
interface riscv_soc_top_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        rdy_in;
    logic        rst_in;
    logic        io_buffer_full;
    logic        sim_putc_valid;
    logic [7:0]  sim_putc_data;
    logic        sim_halt;

    modport master (
        output mem_a, mem_dout, mem_wr,
        input  mem_din, rdy_in, rst_in, io_buffer_full,
        input  sim_putc_valid, sim_putc_data, sim_halt
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr,
        output mem_din, rdy_in, rst_in, io_buffer_full,
        output sim_putc_valid, sim_putc_data, sim_halt
    );
endinterface

// File: rtl/riscv_soc_top.sv
// SoC top: reset conditioning, byte RAM, memory-mapped I/O, 8N1 UART, status LED.
// The RISC-V core attaches through the slave side of the bus interface.
// With SIM=1 the UART is bypassed. Transmit writes and the halt write become
// one-cycle strobes that the simulation harness turns into console output and $finish.
module riscv_soc_top #(
    parameter int SIM            = 0,
    parameter int SYS_CLK_FREQ   = 100000000,
    parameter int UART_BAUD_RATE = 115200,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic       EXCLK,
    input  logic       btnC,
    output logic       Tx,
    input  logic       Rx,
    output logic       led,
    riscv_soc_top_if.slave bus
);

    localparam bit IS_SIM = (SIM != 0);
    localparam int DIV    = SYS_CLK_FREQ / UART_BAUD_RATE;
    localparam int HALF   = DIV / 2;
    localparam int CW     = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- reset conditioning ----------------
    logic [1:0] r_rst_sync;
    logic       w_srst;

    // Two-flop release synchroniser; assertion is immediate through btnC.
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_srst     = ~r_rst_sync[1];
    assign led        = r_rst_sync[1];
    assign bus.rst_in = w_srst;
    assign bus.rdy_in = r_rst_sync[1];

    // ---------------- address decode ----------------
    logic                      w_io_sel;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
    logic [2:0]                w_io_off;
    logic                      w_ram_we;
    logic                      w_io_wr;
    logic                      w_io_rd;
    logic                      w_tx_wr;
    logic                      w_halt_wr;
    logic                      w_pop;
    logic                      w_unused;

    assign w_io_sel   = (bus.mem_a[17:16] == 2'b11);
    assign w_ram_addr = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign w_io_off   = bus.mem_a[2:0];
    assign w_ram_we   = bus.mem_wr & ~w_io_sel & ~w_srst;
    assign w_io_wr    = bus.mem_wr & w_io_sel & ~w_srst;
    assign w_io_rd    = ~bus.mem_wr & w_io_sel & ~w_srst;
    assign w_tx_wr    = w_io_wr & (w_io_off == 3'd0);
    assign w_halt_wr  = w_io_wr & (w_io_off == 3'd4);
    assign w_pop      = w_io_rd & (w_io_off == 3'd0) & ~IS_SIM;
    assign w_unused   = &{1'b0, bus.mem_a[31:18]};

    // ---------------- RAM ----------------
    logic [7:0] r_ram [0:(1 << RAM_ADDR_WIDTH)-1];
    logic [7:0] r_ram_q;

    // Byte RAM; the registered read sees the contents from before a same-cycle write.
    always_ff @(posedge EXCLK) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= bus.mem_dout;
        end
        r_ram_q <= r_ram[w_ram_addr];
    end

    // ---------------- UART receive holding ----------------
    logic       r_rx_valid;
    logic [7:0] r_rx_hold;
    logic       w_rx_done;
    logic [7:0] w_rx_byte;

    // Holding register: a completed frame is kept unless an unpopped byte is already waiting.
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) begin
            r_rx_valid <= 1'b0;
            r_rx_hold  <= 8'h00;
        end else if (w_srst) begin
            r_rx_valid <= 1'b0;
            r_rx_hold  <= 8'h00;
        end else if (w_rx_done && (!r_rx_valid || w_pop)) begin
            r_rx_valid <= 1'b1;
            r_rx_hold  <= w_rx_byte;
        end else if (w_pop) begin
            r_rx_valid <= 1'b0;
        end
    end

    // ---------------- I/O read path and read mux ----------------
    logic [7:0] w_io_rdata;
    logic [7:0] r_io_rdata;
    logic       r_io_sel_q;

    // I/O read data for the offset currently addressed.
    always_comb begin
        w_io_rdata = 8'h00;
        case (w_io_off)
            3'd0:    w_io_rdata = r_rx_valid ? r_rx_hold : 8'h00;
            3'd4:    w_io_rdata = {7'b0000000, r_rx_valid};
            default: w_io_rdata = 8'h00;
        endcase
    end

    // Register the decode and I/O data so both sources share the RAM's one-cycle latency.
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) begin
            r_io_sel_q <= 1'b0;
            r_io_rdata <= 8'h00;
        end else if (w_srst) begin
            r_io_sel_q <= 1'b0;
            r_io_rdata <= 8'h00;
        end else begin
            r_io_sel_q <= w_io_sel;
            r_io_rdata <= w_io_rdata;
        end
    end

    assign bus.mem_din = r_io_sel_q ? r_io_rdata : r_ram_q;

    // ---------------- simulation console strobes ----------------
    logic       r_sim_putc_valid;
    logic [7:0] r_sim_putc_data;
    logic       r_sim_halt;

    // One-cycle console and halt strobes, only ever raised in a SIM=1 build.
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) begin
            r_sim_putc_valid <= 1'b0;
            r_sim_putc_data  <= 8'h00;
            r_sim_halt       <= 1'b0;
        end else if (w_srst) begin
            r_sim_putc_valid <= 1'b0;
            r_sim_putc_data  <= 8'h00;
            r_sim_halt       <= 1'b0;
        end else begin
            r_sim_putc_valid <= IS_SIM & w_tx_wr;
            r_sim_putc_data  <= w_tx_wr ? bus.mem_dout : r_sim_putc_data;
            r_sim_halt       <= IS_SIM & w_halt_wr;
        end
    end

    assign bus.sim_putc_valid = r_sim_putc_valid;
    assign bus.sim_putc_data  = r_sim_putc_data;
    assign bus.sim_halt       = r_sim_halt;

    // ---------------- UART transmitter ----------------
    tx_state_t   r_tx_state, w_tx_state_n;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;
    logic        r_tx_line, w_tx_line_n;
    logic        r_tx_busy, w_tx_busy_n;
    logic        w_tx_load;

    assign w_tx_load          = w_tx_wr & ~IS_SIM & ~r_tx_busy;
    assign Tx                 = r_tx_line;
    assign bus.io_buffer_full = IS_SIM ? 1'b0 : r_tx_busy;

    // Transmitter state register; the line idles high.
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else if (w_srst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_line  <= w_tx_line_n;
            r_tx_busy  <= w_tx_busy_n;
        end
    end

    // Transmitter sequencing: start bit, eight data bits LSB first, stop bit, DIV clocks each.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_line_n  = r_tx_line;
        w_tx_busy_n  = r_tx_busy;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_tx_load) begin
                    w_tx_state_n = TX_START;
                    w_tx_cnt_n   = CNT_ZERO;
                    w_tx_bit_n   = 3'd0;
                    w_tx_shift_n = bus.mem_dout;
                    w_tx_line_n  = 1'b0;
                    w_tx_busy_n  = 1'b1;
                end else begin
                    w_tx_line_n  = 1'b1;
                    w_tx_busy_n  = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_state_n = TX_DATA;
                    w_tx_cnt_n   = CNT_ZERO;
                    w_tx_line_n  = r_tx_shift[0];
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                end else begin
                    w_tx_cnt_n   = r_tx_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_cnt_n = CNT_ZERO;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_tx_line_n  = 1'b1;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_line_n  = r_tx_shift[0];
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_state_n = TX_IDLE;
                    w_tx_cnt_n   = CNT_ZERO;
                    w_tx_line_n  = 1'b1;
                    w_tx_busy_n  = 1'b0;
                end else begin
                    w_tx_cnt_n   = r_tx_cnt + CNT_ONE;
                end
            end
            default: begin
                w_tx_state_n = TX_IDLE;
                w_tx_cnt_n   = CNT_ZERO;
                w_tx_line_n  = 1'b1;
                w_tx_busy_n  = 1'b0;
            end
        endcase
    end

    // ---------------- UART receiver ----------------
    logic [1:0]  r_rx_sync;
    logic        r_rx_d;
    logic        w_rx_s;
    logic        w_rx_in;
    rx_state_t   r_rx_state, w_rx_state_n;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;

    assign w_rx_in   = IS_SIM ? 1'b1 : Rx;
    assign w_rx_s    = r_rx_sync[1];
    assign w_rx_byte = r_rx_shift;

    // Receiver synchroniser, edge-detect delay and state register.
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) begin
            r_rx_sync  <= 2'b11;
            r_rx_d     <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else if (w_srst) begin
            r_rx_sync  <= 2'b11;
            r_rx_d     <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], w_rx_in};
            r_rx_d     <= w_rx_s;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    // Receiver sequencing: confirm the start bit mid-bit, sample data at bit centres, check stop.
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_done    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_d && !w_rx_s) begin
                    w_rx_state_n = RX_START;
                    w_rx_cnt_n   = CNT_ZERO;
                end else begin
                    w_rx_cnt_n   = CNT_ZERO;
                end
            end
            RX_START: begin
                if (r_rx_cnt == HALF_M1) begin
                    w_rx_cnt_n = CNT_ZERO;
                    w_rx_bit_n = 3'd0;
                    if (w_rx_s) begin
                        w_rx_state_n = RX_IDLE;
                    end else begin
                        w_rx_state_n = RX_DATA;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == DIV_M1) begin
                    w_rx_cnt_n   = CNT_ZERO;
                    w_rx_shift_n = {w_rx_s, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_n = RX_STOP;
                    end else begin
                        w_rx_bit_n   = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == DIV_M1) begin
                    w_rx_state_n = RX_IDLE;
                    w_rx_cnt_n   = CNT_ZERO;
                    w_rx_done    = w_rx_s;
                end else begin
                    w_rx_cnt_n   = r_rx_cnt + CNT_ONE;
                end
            end
            default: begin
                w_rx_state_n = RX_IDLE;
                w_rx_cnt_n   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_soc_top.sv
// Bench for riscv_soc_top: the bench plays the core on the bus interface.
// dut0 is a SIM=0 build with DIV=16; dut1 is a SIM=1 build sharing clock, reset and Rx.
module tb_riscv_soc_top;

    logic clk  = 1'b0;
    logic btnC = 1'b1;
    logic rx0  = 1'b1;
    logic tx0, tx1, led0, led1;

    int n_checks = 0;
    int n_pass   = 0;
    int halt_cnt = 0;
    logic [7:0] sim_text [$];
    logic [7:0] ram_model [int unsigned];

    riscv_soc_top_if bus0 ();
    riscv_soc_top_if bus1 ();

    riscv_soc_top #(.SIM(0), .SYS_CLK_FREQ(1600), .UART_BAUD_RATE(100), .RAM_ADDR_WIDTH(17)) dut0 (
        .EXCLK(clk), .btnC(btnC), .Tx(tx0), .Rx(rx0), .led(led0), .bus(bus0)
    );

    riscv_soc_top #(.SIM(1), .SYS_CLK_FREQ(1600), .UART_BAUD_RATE(100), .RAM_ADDR_WIDTH(17)) dut1 (
        .EXCLK(clk), .btnC(btnC), .Tx(tx1), .Rx(rx0), .led(led1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Simulation harness side of the SIM=1 build: console and halt.
    always @(negedge clk) begin
        if (bus1.sim_putc_valid === 1'b1) begin
            $write("%c", bus1.sim_putc_data);
            sim_text.push_back(bus1.sim_putc_data);
        end
        if (bus1.sim_halt === 1'b1) begin
            $display("");
            $display("IO:Return");
            halt_cnt++;
        end
    end

    task automatic bus_wr(input bit sel, input logic [31:0] a, input logic [7:0] d, output logic [7:0] prev);
        @(negedge clk);
        if (sel) begin bus1.mem_a = a; bus1.mem_dout = d; bus1.mem_wr = 1'b1; end
        else     begin bus0.mem_a = a; bus0.mem_dout = d; bus0.mem_wr = 1'b1; end
        @(negedge clk);
        prev = sel ? bus1.mem_din : bus0.mem_din;
        if (sel) begin bus1.mem_a = 32'h0; bus1.mem_wr = 1'b0; end
        else     begin bus0.mem_a = 32'h0; bus0.mem_wr = 1'b0; end
    endtask

    task automatic bus_rd(input bit sel, input logic [31:0] a, output logic [7:0] d);
        @(negedge clk);
        if (sel) begin bus1.mem_a = a; bus1.mem_wr = 1'b0; end
        else     begin bus0.mem_a = a; bus0.mem_wr = 1'b0; end
        @(negedge clk);
        d = sel ? bus1.mem_din : bus0.mem_din;
        if (sel) bus1.mem_a = 32'h0;
        else     bus0.mem_a = 32'h0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        logic [9:0] cells;
        cells = {stop_bit, d, 1'b0};
        for (int c = 0; c < 10; c++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                rx0 = cells[c];
            end
        end
        @(negedge clk);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        bus0.mem_a = 32'h0; bus0.mem_dout = 8'h00; bus0.mem_wr = 1'b0;
        bus1.mem_a = 32'h0; bus1.mem_dout = 8'h00; bus1.mem_wr = 1'b0;
        #2 btnC = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            n_checks++;
            if (led0 !== 1'b0 || led1 !== 1'b0 || tx0 !== 1'b1 || bus0.rst_in !== 1'b1 || bus0.rdy_in !== 1'b0) begin
                $display("FAIL reset_hold cyc %0d: led0=%b led1=%b Tx=%b rst_in=%b rdy_in=%b, want 0 0 1 1 0",
                         i, led0, led1, tx0, bus0.rst_in, bus0.rdy_in);
            end else n_pass++;
        end
        btnC = 1'b1;
        @(negedge clk);
        n_checks++;
        if (led0 !== 1'b0 || bus0.rst_in !== 1'b1) begin
            $display("FAIL reset_edge1: led=%b rst_in=%b, want 0 1", led0, bus0.rst_in);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (led0 !== 1'b1 || led1 !== 1'b1 || bus0.rdy_in !== 1'b1 || bus0.rst_in !== 1'b0
            || tx0 !== 1'b1 || bus0.io_buffer_full !== 1'b0) begin
            $display("FAIL reset_release: led=%b rdy_in=%b rst_in=%b Tx=%b full=%b, want 1 1 0 1 0",
                     led0, bus0.rdy_in, bus0.rst_in, tx0, bus0.io_buffer_full);
        end else n_pass++;
    endtask

    task automatic test_ram_directed();
        logic [7:0] d;
        logic [7:0] prev;
        bus_wr(1'b0, 32'h00010, 8'hA5, prev);
        ram_model[32'h00010] = 8'hA5;
        bus_rd(1'b0, 32'h00010, d);
        n_checks++;
        if (d !== 8'hA5) $display("FAIL ram_rd_0x10: got %h want a5", d); else n_pass++;
        bus_wr(1'b0, 32'h1FFFF, 8'hFF, prev);
        ram_model[32'h1FFFF] = 8'hFF;
        bus_rd(1'b0, 32'h1FFFF, d);
        n_checks++;
        if (d !== 8'hFF) $display("FAIL ram_rd_top: got %h want ff", d); else n_pass++;
        bus_rd(1'b0, 32'h3FFFF, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL io_rd_3ffff: got %h want 00", d); else n_pass++;
        bus_rd(1'b0, 32'hFFFC0010, d);
        n_checks++;
        if (d !== 8'hA5) $display("FAIL ram_alias_hi_bits: got %h want a5", d); else n_pass++;
        bus_wr(1'b0, 32'h00010, 8'h5A, prev);
        ram_model[32'h00010] = 8'h5A;
        n_checks++;
        if (prev !== 8'hA5) $display("FAIL ram_same_cycle_old: got %h want a5", prev); else n_pass++;
        bus_rd(1'b0, 32'h00010, d);
        n_checks++;
        if (d !== 8'h5A) $display("FAIL ram_rd_after_rewrite: got %h want 5a", d); else n_pass++;
    endtask

    task automatic test_ram_random();
        logic [31:0] pool [6];
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  v;
        int unsigned key;
        for (int i = 0; i < 6; i++) begin
            pool[i] = ($urandom & 32'hFFFC0000) | $urandom_range(0, 32'h2FFFF);
        end
        for (int i = 0; i < 60; i++) begin
            a   = pool[$urandom_range(0, 5)];
            key = a % 32'h20000;
            if ($urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                bus_wr(1'b0, a, v, d);
                if (ram_model.exists(key)) begin
                    n_checks++;
                    if (d !== ram_model[key]) $display("FAIL ram_rand_wr_old a=%h: got %h want %h", a, d, ram_model[key]);
                    else n_pass++;
                end
                ram_model[key] = v;
            end else begin
                bus_rd(1'b0, a, d);
                if (ram_model.exists(key)) begin
                    n_checks++;
                    if (d !== ram_model[key]) $display("FAIL ram_rand_rd a=%h: got %h want %h", a, d, ram_model[key]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_io_map();
        logic [7:0] d;
        logic [7:0] prev;
        bus_rd(1'b0, 32'h30000, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL io_rx_empty: got %h want 00", d); else n_pass++;
        bus_rd(1'b0, 32'h30004, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL io_status_empty: got %h want 00", d); else n_pass++;
        bus_rd(1'b0, 32'h30003, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL io_other_off: got %h want 00", d); else n_pass++;
        bus_wr(1'b0, 32'h30001, 8'h12, prev);
        bus_wr(1'b0, 32'h30004, 8'h34, prev);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus0.io_buffer_full !== 1'b0 || tx0 !== 1'b1)
            $display("FAIL io_other_wr: full=%b Tx=%b want 0 1", bus0.io_buffer_full, tx0);
        else n_pass++;
    endtask

    task automatic test_tx(input logic [7:0] data);
        logic [9:0] frame;
        logic       exp_line;
        logic       exp_busy;
        frame = {1'b1, data, 1'b0};
        @(negedge clk);
        bus0.mem_a = 32'h30000; bus0.mem_dout = data; bus0.mem_wr = 1'b1;
        @(negedge clk);
        bus0.mem_a = 32'h0; bus0.mem_wr = 1'b0;
        for (int k = 1; k <= 175; k++) begin
            exp_line = (k <= 160) ? frame[(k - 1) / 16] : 1'b1;
            exp_busy = (k <= 160);
            n_checks++;
            if (tx0 !== exp_line || bus0.io_buffer_full !== exp_busy)
                $display("FAIL tx_%h clk %0d: Tx=%b full=%b want %b %b", data, k, tx0, bus0.io_buffer_full, exp_line, exp_busy);
            else n_pass++;
            if (k == 40) begin
                bus0.mem_a = 32'h30000; bus0.mem_dout = ~data; bus0.mem_wr = 1'b1;
            end else if (k == 41) begin
                bus0.mem_a = 32'h0; bus0.mem_wr = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rx();
        logic [7:0] d;
        logic [7:0] v;
        send_rx(8'h3C, 1'b1);
        send_rx(8'h7E, 1'b1);
        bus_rd(1'b0, 32'h30004, d);
        n_checks++;
        if (d !== 8'h01) $display("FAIL rx_status_full: got %h want 01", d); else n_pass++;
        bus_rd(1'b0, 32'h30000, d);
        n_checks++;
        if (d !== 8'h3C) $display("FAIL rx_overrun_keep: got %h want 3c", d); else n_pass++;
        bus_rd(1'b0, 32'h30004, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rx_status_popped: got %h want 00", d); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            send_rx(v, 1'b1);
            bus_rd(1'b0, 32'h30000, d);
            n_checks++;
            if (d !== v) $display("FAIL rx_rand_%0d: got %h want %h", i, d, v); else n_pass++;
            bus_rd(1'b0, 32'h30000, d);
            n_checks++;
            if (d !== 8'h00) $display("FAIL rx_rand_empty_%0d: got %h want 00", i, d); else n_pass++;
        end
        @(negedge clk); rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        bus_rd(1'b0, 32'h30004, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rx_glitch: got %h want 00", d); else n_pass++;
        send_rx(8'hA3, 1'b0);
        bus_rd(1'b0, 32'h30004, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rx_bad_stop: got %h want 00", d); else n_pass++;
        send_rx(8'h81, 1'b1);
        bus_rd(1'b0, 32'h30000, d);
        n_checks++;
        if (d !== 8'h81) $display("FAIL rx_after_bad_stop: got %h want 81", d); else n_pass++;
    endtask

    task automatic test_sim_console();
        logic [7:0] d;
        logic [7:0] prev;
        logic       ok;
        bus_rd(1'b1, 32'h30004, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL sim_rx_status: got %h want 00", d); else n_pass++;
        bus_rd(1'b1, 32'h30000, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL sim_rx_data: got %h want 00", d); else n_pass++;
        bus_wr(1'b1, 32'h30000, 8'h48, prev);
        n_checks++;
        if (bus1.io_buffer_full !== 1'b0 || tx1 !== 1'b1)
            $display("FAIL sim_bypass: full=%b Tx=%b want 0 1", bus1.io_buffer_full, tx1);
        else n_pass++;
        bus_wr(1'b1, 32'h30000, 8'h69, prev);
        repeat (2) @(negedge clk);
        ok = (sim_text.size() == 2) ? (sim_text[0] == 8'h48 && sim_text[1] == 8'h69) : 1'b0;
        n_checks++;
        if (!ok) $display("FAIL sim_putc: got %0d chars, want 2 chars 48 69", sim_text.size());
        else n_pass++;
        n_checks++;
        if (halt_cnt != 0) $display("FAIL sim_early_halt: got %0d halts want 0", halt_cnt); else n_pass++;
        bus_wr(1'b1, 32'h30004, 8'($urandom), prev);
        repeat (2) @(negedge clk);
        n_checks++;
        if (halt_cnt != 1) $display("FAIL sim_halt: got %0d halts want 1", halt_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ram_directed();
        test_ram_random();
        test_io_map();
        test_tx(8'h55);
        test_tx(8'($urandom));
        test_rx();
        test_sim_console();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
